// File: rtl/sim_end_checker.sv
// End-of-simulation checker: waits for the core to retire the END_PC instruction,
// then compares a small table of register expectations through the RF debug port.
module sim_end_checker #(
    parameter int               NUM_CHECKS = 2,
    parameter int               DATA_W     = 32,
    parameter int               PC_W       = 32,
    parameter logic [PC_W-1:0]  END_PC     = 32'h1c000018,
    parameter int               TIMEOUT    = 1000000,
    localparam int              IDX_W      = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_we,
    input  logic [IDX_W-1:0]  cfg_idx,
    input  logic              cfg_en,
    input  logic [4:0]        cfg_reg,
    input  logic [DATA_W-1:0] cfg_exp,
    input  logic              wb_valid,
    input  logic [PC_W-1:0]   wb_pc,
    output logic [4:0]        rf_raddr,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic              timeout,
    output logic [IDX_W-1:0]  fail_idx,
    output logic [DATA_W-1:0] fail_data
);

    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CHECKS - 1);

    typedef enum logic [2:0] {
        S_RUN   = 3'd0,
        S_CHECK = 3'd1,
        S_PASS  = 3'd2,
        S_FAIL  = 3'd3,
        S_TOUT  = 3'd4
    } state_t;

    state_t              state;
    state_t              next_state;
    logic [IDX_W-1:0]    idx;
    logic [CNT_W-1:0]    cnt;
    logic                en_q  [NUM_CHECKS];
    logic [4:0]          reg_q [NUM_CHECKS];
    logic [DATA_W-1:0]   exp_q [NUM_CHECKS];

    logic trigger;
    logic cfg_ok;
    logic entry_bad;

    assign trigger   = wb_valid && (wb_pc == END_PC);
    assign cfg_ok    = cfg_we && (state == S_RUN) &&
                       ({1'b0, cfg_idx} < (IDX_W + 1)'(NUM_CHECKS));
    assign entry_bad = en_q[idx] && (rf_rdata != exp_q[idx]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_RUN;
        else       state <= next_state;
    end

    // A trigger in the last RUN cycle still beats the timeout.
    always_comb begin
        next_state = state;
        case (state)
            S_RUN: begin
                if (trigger)              next_state = S_CHECK;
                else if (cnt == CNT_LAST) next_state = S_TOUT;
            end
            S_CHECK: begin
                if (entry_bad)            next_state = S_FAIL;
                else if (idx == IDX_LAST) next_state = S_PASS;
            end
            default: next_state = state;
        endcase
    end

    always_comb begin
        rf_raddr = '0;
        if (state == S_CHECK) rf_raddr = reg_q[idx];
    end

    // Status flags are registered from next_state so they line up with the state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx       <= '0;
            cnt       <= '0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail      <= 1'b0;
            timeout   <= 1'b0;
            fail_idx  <= '0;
            fail_data <= '0;
            for (int i = 0; i < NUM_CHECKS; i++) begin
                en_q[i]  <= 1'b0;
                reg_q[i] <= '0;
                exp_q[i] <= '0;
            end
        end else begin
            if (state == S_RUN && cnt != CNT_MAX) cnt <= cnt + 1'b1;

            if (state == S_RUN)                                 idx <= '0;
            else if (state == S_CHECK && next_state == S_CHECK) idx <= idx + 1'b1;

            if (cfg_ok) begin
                en_q[cfg_idx]  <= cfg_en;
                reg_q[cfg_idx] <= cfg_reg;
                exp_q[cfg_idx] <= cfg_exp;
            end

            done    <= (next_state == S_PASS) || (next_state == S_FAIL) || (next_state == S_TOUT);
            pass    <= (next_state == S_PASS);
            fail    <= (next_state == S_FAIL);
            timeout <= (next_state == S_TOUT);

            if (state == S_CHECK && next_state == S_FAIL) begin
                fail_idx  <= idx;
                fail_data <= rf_rdata;
            end
        end
    end

endmodule

// File: tb/tb_sim_end_checker.sv
// Bench for sim_end_checker: directed scenarios plus randomized configurations
// checked against an outcome model of the register-check table.
module tb_sim_end_checker;

    localparam int          NUM_CHECKS = 2;
    localparam int          DATA_W     = 32;
    localparam int          PC_W       = 32;
    localparam int          TIMEOUT    = 16;
    localparam int          IDX_W      = 1;
    localparam logic [31:0] END_PC     = 32'h1c000018;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              cfg_we = 1'b0;
    logic [IDX_W-1:0]  cfg_idx = '0;
    logic              cfg_en = 1'b0;
    logic [4:0]        cfg_reg = '0;
    logic [DATA_W-1:0] cfg_exp = '0;
    logic              wb_valid = 1'b0;
    logic [PC_W-1:0]   wb_pc = '0;
    logic [4:0]        rf_raddr;
    logic [DATA_W-1:0] rf_rdata;
    logic              done, pass, fail, timeout;
    logic [IDX_W-1:0]  fail_idx;
    logic [DATA_W-1:0] fail_data;

    logic [DATA_W-1:0] rf_mem [32];
    logic [36:0]       status;

    logic              m_en  [NUM_CHECKS];
    logic [4:0]        m_reg [NUM_CHECKS];
    logic [DATA_W-1:0] m_exp [NUM_CHECKS];

    int vectors = 0;
    int miscompares = 0;

    sim_end_checker #(
        .NUM_CHECKS(NUM_CHECKS), .DATA_W(DATA_W), .PC_W(PC_W),
        .END_PC(END_PC), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_en(cfg_en), .cfg_reg(cfg_reg), .cfg_exp(cfg_exp),
        .wb_valid(wb_valid), .wb_pc(wb_pc),
        .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
        .done(done), .pass(pass), .fail(fail), .timeout(timeout),
        .fail_idx(fail_idx), .fail_data(fail_data)
    );

    always #5 clk = ~clk;

    assign rf_rdata = rf_mem[rf_raddr];
    assign status   = {done, pass, fail, timeout, fail_idx, fail_data};

    function automatic logic [36:0] pack(input logic d, input logic p, input logic f, input logic t,
                                         input logic [IDX_W-1:0] i, input logic [31:0] data);
        return {d, p, f, t, i, data};
    endfunction

    // Outcome of a trigger: the first enabled entry whose register differs fails
    // after (index+1) cycles, otherwise pass after NUM_CHECKS cycles.
    function automatic void predict(output int lat, output logic [36:0] res);
        lat = NUM_CHECKS;
        res = pack(1'b1, 1'b1, 1'b0, 1'b0, '0, '0);
        for (int k = 0; k < NUM_CHECKS; k++) begin
            if (m_en[k] && rf_mem[m_reg[k]] !== m_exp[k]) begin
                lat = k + 1;
                res = pack(1'b1, 1'b0, 1'b1, 1'b0, IDX_W'(k), rf_mem[m_reg[k]]);
                break;
            end
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reset is released just after an edge; that edge is edge 1 after release.
    task automatic do_reset();
        reset    = 1'b1;
        cfg_we   = 1'b0;
        wb_valid = 1'b0;
        wb_pc    = '0;
        for (int k = 0; k < NUM_CHECKS; k++) begin
            m_en[k]  = 1'b0;
            m_reg[k] = '0;
            m_exp[k] = '0;
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic cfg_write(input int idx, input logic en, input logic [4:0] r, input logic [31:0] e);
        cfg_we  = 1'b1;
        cfg_idx = IDX_W'(idx);
        cfg_en  = en;
        cfg_reg = r;
        cfg_exp = e;
        m_en[idx]  = en;
        m_reg[idx] = r;
        m_exp[idx] = e;
        step();
        cfg_we = 1'b0;
    endtask

    task automatic fire_trigger();
        wb_valid = 1'b1;
        wb_pc    = END_PC;
        step();
        wb_valid = 1'b0;
        wb_pc    = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        vectors++;
        if ({status, rf_raddr} !== 42'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: got=%h want=0", {status, rf_raddr});
        end
        do_reset();
        vectors++;
        if (status !== 37'h0) begin
            miscompares++;
            $display("FAIL after_release: got=%h want=0", status);
        end
    endtask

    task automatic test_pass();
        do_reset();
        rf_mem[5] = 32'h5a;
        rf_mem[8] = 32'h56;
        cfg_write(0, 1'b1, 5'd5, 32'h5a);
        cfg_write(1, 1'b1, 5'd8, 32'h56);
        fire_trigger();
        vectors++;
        if ({status, rf_raddr} !== {37'h0, 5'd5}) begin
            miscompares++;
            $display("FAIL pass_check0: got=%h want=%h", {status, rf_raddr}, {37'h0, 5'd5});
        end
        step();
        vectors++;
        if ({status, rf_raddr} !== {37'h0, 5'd8}) begin
            miscompares++;
            $display("FAIL pass_check1: got=%h want=%h", {status, rf_raddr}, {37'h0, 5'd8});
        end
        step();
        vectors++;
        if ({status, rf_raddr} !== {pack(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0), 5'd0}) begin
            miscompares++;
            $display("FAIL pass_result: got=%h want=%h", {status, rf_raddr},
                     {pack(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0), 5'd0});
        end
    endtask

    task automatic test_fail_hold();
        logic [36:0] want;
        do_reset();
        rf_mem[5] = 32'h5a;
        rf_mem[8] = 32'h57;
        cfg_write(0, 1'b1, 5'd5, 32'h5a);
        cfg_write(1, 1'b1, 5'd8, 32'h56);
        fire_trigger();
        step();
        step();
        want = pack(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h57);
        for (int c = 0; c < 100; c++) begin
            vectors++;
            if (status !== want) begin
                miscompares++;
                $display("FAIL fail_hold cycle %0d: got=%h want=%h", c, status, want);
            end
            cfg_we   = 1'($urandom_range(0, 1));
            cfg_idx  = 1'($urandom_range(0, 1));
            cfg_en   = 1'b1;
            cfg_exp  = $urandom;
            wb_valid = 1'($urandom_range(0, 1));
            wb_pc    = END_PC;
            step();
        end
        cfg_we   = 1'b0;
        wb_valid = 1'b0;
    endtask

    task automatic test_timeout();
        do_reset();
        for (int c = 2; c <= TIMEOUT; c++) step();
        vectors++;
        if (status !== 37'h0) begin
            miscompares++;
            $display("FAIL timeout_early: got=%h want=0", status);
        end
        step();
        vectors++;
        if (status !== pack(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0)) begin
            miscompares++;
            $display("FAIL timeout_edge17: got=%h want=%h", status, pack(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0));
        end
        fire_trigger();
        step();
        step();
        vectors++;
        if ({status, rf_raddr} !== {pack(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0), 5'd0}) begin
            miscompares++;
            $display("FAIL timeout_sticky: got=%h", {status, rf_raddr});
        end
    endtask

    task automatic test_trigger_at_limit();
        do_reset();
        for (int c = 2; c <= TIMEOUT; c++) step();
        fire_trigger();
        vectors++;
        if (status !== 37'h0) begin
            miscompares++;
            $display("FAIL limit_trigger: got=%h want=0", status);
        end
        step();
        step();
        vectors++;
        if (status !== pack(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0)) begin
            miscompares++;
            $display("FAIL limit_pass: got=%h want=%h", status, pack(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0));
        end
    endtask

    task automatic test_cfg_during_check();
        do_reset();
        rf_mem[3] = 32'h22;
        rf_mem[9] = 32'h99;
        cfg_write(0, 1'b0, 5'd3, 32'h11);
        cfg_write(1, 1'b1, 5'd9, 32'h99);
        fire_trigger();
        cfg_we  = 1'b1;
        cfg_idx = 1'b1;
        cfg_en  = 1'b1;
        cfg_reg = 5'd9;
        cfg_exp = 32'hbad;
        step();
        cfg_we = 1'b0;
        step();
        vectors++;
        if (status !== pack(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0)) begin
            miscompares++;
            $display("FAIL cfg_in_check: got=%h want=%h", status, pack(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0));
        end
    endtask

    task automatic test_reset_mid_check();
        do_reset();
        rf_mem[6] = 32'h1;
        rf_mem[7] = 32'h2;
        cfg_write(0, 1'b1, 5'd6, 32'h77);
        cfg_write(1, 1'b1, 5'd7, 32'h78);
        fire_trigger();
        #2;
        reset = 1'b1;
        #1;
        vectors++;
        if ({status, rf_raddr} !== 42'h0) begin
            miscompares++;
            $display("FAIL async_reset: got=%h want=0", {status, rf_raddr});
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        fire_trigger();
        step();
        vectors++;
        if (status !== 37'h0) begin
            miscompares++;
            $display("FAIL post_reset_mid: got=%h want=0", status);
        end
        step();
        vectors++;
        if (status !== pack(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0)) begin
            miscompares++;
            $display("FAIL post_reset_pass: got=%h want=%h", status, pack(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0));
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        rf_mem[4] = 32'h45;
        cfg_we   = 1'b1;
        cfg_idx  = 1'b1;
        cfg_en   = 1'b1;
        cfg_reg  = 5'd4;
        cfg_exp  = 32'h44;
        wb_valid = 1'b1;
        wb_pc    = END_PC;
        step();
        cfg_we   = 1'b0;
        wb_valid = 1'b0;
        step();
        vectors++;
        if (status !== 37'h0) begin
            miscompares++;
            $display("FAIL b2b_mid: got=%h want=0", status);
        end
        step();
        vectors++;
        if (status !== pack(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h45)) begin
            miscompares++;
            $display("FAIL b2b_fail: got=%h want=%h", status, pack(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h45));
        end
    endtask

    task automatic test_random(input int iters);
        int          lat;
        int          nw;
        int          idle;
        int          r;
        logic [36:0] res;
        for (int it = 0; it < iters; it++) begin
            do_reset();
            for (int k = 0; k < 32; k++) rf_mem[k] = $urandom_range(0, 3);
            nw = $urandom_range(0, 3);
            for (int w = 0; w < nw; w++) begin
                r = $urandom_range(0, 31);
                cfg_write($urandom_range(0, NUM_CHECKS - 1), 1'($urandom_range(0, 1)), 5'(r),
                          ($urandom_range(0, 1) == 1) ? rf_mem[r] : 32'($urandom_range(0, 3)));
            end
            idle = $urandom_range(0, 5);
            for (int s = 0; s < idle; s++) begin
                wb_valid = 1'($urandom_range(0, 1));
                wb_pc    = END_PC + 32'd4;
                step();
            end
            fire_trigger();
            predict(lat, res);
            for (int c = 0; c < lat; c++) begin
                vectors++;
                if ({done, rf_raddr} !== {1'b0, m_reg[c]}) begin
                    miscompares++;
                    $display("FAIL rand_check it%0d c%0d: got=%h want=%h", it, c, {done, rf_raddr}, {1'b0, m_reg[c]});
                end
                step();
            end
            for (int c = 0; c < 3; c++) begin
                vectors++;
                if (status !== res) begin
                    miscompares++;
                    $display("FAIL rand_result it%0d c%0d: got=%h want=%h", it, c, status, res);
                end
                cfg_we   = 1'($urandom_range(0, 1));
                cfg_idx  = 1'($urandom_range(0, 1));
                cfg_en   = 1'b1;
                cfg_exp  = $urandom;
                wb_valid = 1'($urandom_range(0, 1));
                wb_pc    = END_PC;
                step();
            end
            cfg_we   = 1'b0;
            wb_valid = 1'b0;
        end
    endtask

    initial begin
        for (int k = 0; k < 32; k++) rf_mem[k] = '0;
        test_reset();
        test_pass();
        test_fail_hold();
        test_timeout();
        test_trigger_at_limit();
        test_cfg_during_check();
        test_reset_mid_check();
        test_back_to_back();
        test_random(40);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sim_end_checker.md
SIM_END_CHECKER -- requirements
Module: sim_end_checker

Interface
REQ-001 SHALL have parameter NUM_CHECKS, default 2, number of register-check entries (1..8).
REQ-002 SHALL have parameter DATA_W, default 32, register data width.
REQ-003 SHALL have parameter PC_W, default 32, PC width.
REQ-004 SHALL have parameter END_PC, default 32'h1c000018, writeback PC that triggers checking.
REQ-005 SHALL have parameter TIMEOUT, default 1000000, cycles allowed in RUN before a timeout.
REQ-006 SHALL define IDX_W = max(1, clog2(NUM_CHECKS)) as a derived local width.
REQ-007 SHALL have port clk  in  1  clock; all state SHALL update on the rising edge.
REQ-008 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-009 SHALL have port cfg_we  in  1  check-entry write strobe.
REQ-010 SHALL have port cfg_idx  in  IDX_W  entry index being written.
REQ-011 SHALL have port cfg_en  in  1  entry enable value.
REQ-012 SHALL have port cfg_reg  in  5  register number to check.
REQ-013 SHALL have port cfg_exp  in  DATA_W  expected register value.
REQ-014 SHALL have port wb_valid  in  1  writeback retire valid.
REQ-015 SHALL have port wb_pc  in  PC_W  PC of the retiring instruction.
REQ-016 SHALL have port rf_raddr  out  5  register-file debug read address.
REQ-017 SHALL have port rf_rdata  in  DATA_W  register-file read data, combinational from rf_raddr.
REQ-018 SHALL have ports done, pass, fail, timeout  out  1 each  status flags.
REQ-019 SHALL have ports fail_idx  out  IDX_W  and fail_data  out  DATA_W  first-mismatch capture.

Function
REQ-020 SHALL implement FSM states RUN, CHECK, PASS, FAIL, TOUT; reset state SHALL be RUN.
REQ-021 In RUN, a saturating cycle counter of width clog2(TIMEOUT+1) SHALL increment every cycle; it SHALL be cleared by reset only.
REQ-022 In RUN, wb_valid=1 with wb_pc==END_PC SHALL move to CHECK next cycle with entry index 0.
REQ-023 In RUN, a counter value of TIMEOUT-1 without a trigger SHALL move to TOUT next cycle; a trigger in the same cycle SHALL win (go to CHECK).
REQ-024 In CHECK, rf_raddr SHALL equal the current entry's reg field; rf_raddr SHALL be 0 in all other states.
REQ-025 In CHECK, each cycle SHALL evaluate one entry: enabled and rf_rdata!=exp -> FAIL, capturing fail_idx=index and fail_data=rf_rdata.
REQ-026 In CHECK, a disabled or matching entry SHALL advance the index; a pass at index NUM_CHECKS-1 SHALL go to PASS.
REQ-027 Check latency SHALL be exactly NUM_CHECKS cycles from CHECK entry to PASS when all entries pass.
REQ-028 With no entries enabled, a trigger SHALL still reach PASS after NUM_CHECKS cycles.
REQ-029 PASS, FAIL, TOUT SHALL be terminal and sticky until reset; wb_* and cfg_* SHALL be ignored there.
REQ-030 cfg writes SHALL take effect only in RUN; writes in any other state, or with cfg_idx>=NUM_CHECKS, SHALL be ignored.
REQ-031 A cfg write and a trigger in the same cycle SHALL both take effect; the written entry SHALL be used by CHECK.
REQ-032 Status outputs SHALL be registered: done=1 in PASS/FAIL/TOUT; pass, fail, timeout SHALL be one-hot and asserted only with done.
REQ-033 fail_idx and fail_data SHALL hold their captured values after FAIL and remain 0 otherwise.

Reset
REQ-034 reset=1 SHALL asynchronously force state RUN, index 0, counter 0, all entries en=0/reg=0/exp=0, and every output 0.
REQ-035 reset asserted mid-CHECK or in a terminal state SHALL discard all progress; checking SHALL restart only from a new trigger after reset release.

Verification
REQ-036 NUM_CHECKS=2, entries {r5=0x5a, r8=0x56}, rf returns 0x5a/0x56, trigger wb_pc=0x1c000018 -> pass=1, done=1 two cycles after CHECK entry, fail=0.
REQ-037 Same setup, r8 returns 0x57 -> fail=1, fail_idx=1, fail_data=0x57, pass=0, all held for 100 further cycles.
REQ-038 TIMEOUT=16, no trigger -> timeout=1, done=1 on the 17th rising edge after reset release; later triggers ignored.
REQ-039 TIMEOUT=16, trigger at counter=15 -> CHECK entered, timeout stays 0, pass follows.
REQ-040 Entry 0 disabled with exp mismatching, entry 1 matching; cfg write to entry 1 during CHECK with bad exp -> pass=1 (write ignored).
REQ-041 reset pulsed during CHECK -> all outputs 0 immediately, entries cleared; a fresh trigger without config -> pass after 2 cycles.
